writeback_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file; owns its single write port (wen/wsel/wdat).
- Merges two result producers into that port:
  - single-cycle ALU/MEM pipeline result stream;
  - multi-cycle mul/div unit result stream.
- Mul/div results are buffered in a small FIFO. The ALU has default priority, and a starvation counter guarantees FIFO forward progress.

---
 rtl/writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the ALU/MEM result stream and a FIFO-buffered mul/div stream onto
// the single register-file write port. Define WB_STALE_KILL_EN to drop stale buffered results.
module writeback_arbiter #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MD_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_wsel,
    input  logic [WORD_W-1:0] alu_wdat,
    output logic              wb_stall,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_wsel,
    input  logic [WORD_W-1:0] md_wdat,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic              md_pending
);

    localparam int unsigned PTR_W = $clog2(MD_DEPTH);
    localparam int unsigned CNT_W = $clog2(MD_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [REG_AW-1:0]   fifo_wsel_q [MD_DEPTH];
    logic [WORD_W-1:0]   fifo_wdat_q [MD_DEPTH];
    logic [MD_DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                ready_q, ready_d;
    logic                pending_q, pending_d;
    logic                wen_q, wen_d;
    logic [REG_AW-1:0]   wsel_q, wsel_d;
    logic [WORD_W-1:0]   wdat_q, wdat_d;

    logic fifo_ne, head_live, head_dead, alu_acc, push, pop, sel_fifo, sel_alu;

    always_comb begin
        fifo_ne   = (cnt_q != '0);
        head_live = fifo_ne && ent_vld_q[rd_ptr_q];
        // A dead head only exists once an entry has been invalidated by a younger ALU write.
        head_dead = fifo_ne && !ent_vld_q[rd_ptr_q];
        alu_acc   = alu_valid && !stall_q;
        push      = md_valid && ready_q && (md_wsel != '0);

        sel_fifo = 1'b0;
        sel_alu  = 1'b0;
        if (stall_q && head_live) begin
            sel_fifo = 1'b1;
        end else if (alu_acc && (alu_wsel != '0)) begin
            sel_alu = 1'b1;
        end else if (head_live) begin
            sel_fifo = 1'b1;
        end
        pop = sel_fifo || head_dead;

        wen_d  = sel_fifo || sel_alu;
        wsel_d = '0;
        wdat_d = '0;
        if (sel_fifo) begin
            wsel_d = fifo_wsel_q[rd_ptr_q];
            wdat_d = fifo_wdat_q[rd_ptr_q];
        end else if (sel_alu) begin
            wsel_d = alu_wsel;
            wdat_d = alu_wdat;
        end

        ent_vld_d = ent_vld_q;
        if (pop) ent_vld_d[rd_ptr_q] = 1'b0;
`ifdef WB_STALE_KILL_EN
        if (sel_alu) begin
            for (int i = 0; i < int'(MD_DEPTH); i++) begin
                if (ent_vld_q[i] && (fifo_wsel_q[i] == alu_wsel)) ent_vld_d[i] = 1'b0;
            end
        end
`endif
        // Applied after the kill so a same-cycle arrival to the killed register survives.
        if (push) ent_vld_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        starve_d = '0;
        if (head_live && !pop) begin
            starve_d = (starve_q < STV_W'(STARVE_LIMIT)) ? starve_q + STV_W'(1) : starve_q;
        end
        stall_d   = (starve_d >= STV_W'(STARVE_LIMIT));
        ready_d   = (cnt_d < CNT_W'(MD_DEPTH));
        pending_d = (cnt_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            wen_q     <= 1'b0;
            wsel_q    <= '0;
            wdat_q    <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
            wen_q     <= wen_d;
            wsel_q    <= wsel_d;
            wdat_q    <= wdat_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by ent_vld_q and cnt_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_wsel_q[wr_ptr_q] <= md_wsel;
            fifo_wdat_q[wr_ptr_q] <= md_wdat;
        end
    end

    assign wb_stall   = stall_q;
    assign md_ready   = ready_q;
    assign md_pending = pending_q;
    assign rf_wen     = wen_q;
    assign rf_wsel    = wsel_q;
    assign rf_wdat    = wdat_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned MD_DEPTH     = 2;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef WB_STALE_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_wsel;
    logic [WORD_W-1:0] alu_wdat;
    logic              wb_stall;
    logic              md_valid;
    logic              md_ready;
    logic [REG_AW-1:0] md_wsel;
    logic [WORD_W-1:0] md_wdat;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_wsel;
    logic [WORD_W-1:0] rf_wdat;
    logic              md_pending;

    writeback_arbiter #(
        .WORD_W      (WORD_W),
        .REG_AW      (REG_AW),
        .MD_DEPTH    (MD_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .alu_valid (alu_valid),
        .alu_wsel  (alu_wsel),
        .alu_wdat  (alu_wdat),
        .wb_stall  (wb_stall),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_wsel   (md_wsel),
        .md_wdat   (md_wdat),
        .rf_wen    (rf_wen),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .md_pending(md_pending)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [REG_AW-1:0] wsel;
        logic [WORD_W-1:0] wdat;
        bit                live;
    } ent_t;

    // Reference model state: buffered results in arrival order plus expected registered outputs.
    ent_t              mq[$];
    int                m_starve;
    bit                m_stall, m_ready, m_pending, m_wen;
    logic [REG_AW-1:0] m_wsel;
    logic [WORD_W-1:0] m_wdat;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit head_live, head_dead, acc, push, pop_live, alu_w;
        ent_t e;
        if (RST) begin
            mq.delete();
            m_starve  = 0;
            m_stall   = 1'b0;
            m_ready   = 1'b1;
            m_pending = 1'b0;
            m_wen     = 1'b0;
            m_wsel    = '0;
            m_wdat    = '0;
        end else begin
            head_live = (mq.size() > 0) && mq[0].live;
            head_dead = (mq.size() > 0) && !mq[0].live;
            acc       = alu_valid && !m_stall;
            push      = md_valid && m_ready && (md_wsel != 0);
            pop_live  = 1'b0;
            alu_w     = 1'b0;
            if (m_stall && head_live) pop_live = 1'b1;
            else if (acc && alu_wsel != 0) alu_w = 1'b1;
            else if (head_live) pop_live = 1'b1;
            m_wen = pop_live || alu_w;
            if (pop_live) begin
                m_wsel = mq[0].wsel;
                m_wdat = mq[0].wdat;
            end else if (alu_w) begin
                m_wsel = alu_wsel;
                m_wdat = alu_wdat;
            end
            if (KILL && alu_w) begin
                foreach (mq[i]) if (mq[i].wsel == alu_wsel) mq[i].live = 1'b0;
            end
            if (pop_live || head_dead) void'(mq.pop_front());
            if (head_live && !pop_live) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else m_starve = 0;
            m_stall = (m_starve >= STARVE_LIMIT);
            if (push) begin
                e.wsel = md_wsel;
                e.wdat = md_wdat;
                e.live = 1'b1;
                mq.push_back(e);
            end
            m_ready   = (mq.size() < MD_DEPTH);
            m_pending = (mq.size() != 0);
        end
    endtask

    // Advance one clock; the model consumes the same inputs the DUT sampled at that edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic drv_alu(input bit v, input int s, input logic [WORD_W-1:0] d);
        alu_valid = v;
        alu_wsel  = REG_AW'(s);
        alu_wdat  = d;
    endtask

    task automatic drv_md(input bit v, input int s, input logic [WORD_W-1:0] d);
        md_valid = v;
        md_wsel  = REG_AW'(s);
        md_wdat  = d;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_wen", rf_wen, m_wen);
            check("model_stall", wb_stall, m_stall);
            check("model_ready", md_ready, m_ready);
            check("model_pending", md_pending, m_pending);
            if (m_wen) begin
                check("model_wsel", rf_wsel, m_wsel);
                check("model_wdat", rf_wdat, m_wdat);
            end
        end
    end

    initial begin
        RST = 1'b1;
        drv_alu(0, 0, 0);
        drv_md(1, 4, 32'h5);
        tick();
        tick();
        RST = 1'b0;
        drv_md(0, 0, 0);
        chk_en = 1'b1;
        check("rst_wen", rf_wen, 0);
        check("rst_wsel", rf_wsel, 0);
        check("rst_wdat", rf_wdat, 0);
        check("rst_stall", wb_stall, 0);
        check("rst_ready", md_ready, 1);
        check("rst_pending", md_pending, 0);
        tick();
        check("idle_wen", rf_wen, 0);
        check("idle_pending", md_pending, 0);

        // Plain ALU stream, including a discarded r0 write.
        drv_alu(1, 3, 32'hDEADBEEF);
        tick();
        check("alu_wen", rf_wen, 1);
        check("alu_wsel", rf_wsel, 3);
        check("alu_wdat", rf_wdat, 32'hDEADBEEF);
        drv_alu(1, 0, 32'h1);
        tick();
        check("alu_r0_wen", rf_wen, 0);
        drv_alu(0, 0, 0);

        // MD buffering.
        drv_md(1, 7, 32'h11);
        tick();
        check("md1_wen", rf_wen, 0);
        check("md1_pending", md_pending, 1);
        drv_md(1, 8, 32'h22);
        tick();
        check("md1_wsel", rf_wsel, 7);
        check("md1_wdat", rf_wdat, 32'h11);
        check("md1_ready", md_ready, 1);
        drv_md(0, 0, 0);
        tick();
        check("md2_wsel", rf_wsel, 8);
        check("md2_wdat", rf_wdat, 32'h22);
        check("md2_pending", md_pending, 0);
        tick();
        check("md_idle_wen", rf_wen, 0);

        // Starvation: ALU wins four times, then the buffered result is forced through.
        drv_md(1, 9, 32'h33);
        tick();
        drv_md(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            drv_alu(1, k, 32'h100 + k);
            tick();
            check("stv_alu_wsel", rf_wsel, k);
            check("stv_stall", wb_stall, (k == 4) ? 1 : 0);
        end
        drv_alu(1, 5, 32'h105);
        tick();
        check("stv_md_wsel", rf_wsel, 9);
        check("stv_md_wdat", rf_wdat, 32'h33);
        check("stv_unstall", wb_stall, 0);
        tick();
        check("stv_held_wsel", rf_wsel, 5);
        check("stv_held_wdat", rf_wdat, 32'h105);
        drv_alu(0, 0, 0);
        tick();

        // Fill the FIFO behind ALU traffic, then drain with pushes across the pointer wrap.
        drv_alu(1, 10, 32'h10);
        drv_md(1, 20, 32'hA0);
        tick();
        drv_alu(1, 11, 32'h11);
        drv_md(1, 21, 32'hA1);
        tick();
        check("full_ready", md_ready, 0);
        drv_alu(0, 0, 0);
        drv_md(1, 22, 32'hA2);
        tick();
        check("wrap_w20", rf_wsel, 20);
        check("wrap_pend", md_pending, 1);
        tick();
        check("wrap_w21", rf_wsel, 21);
        drv_md(1, 23, 32'hA3);
        tick();
        check("wrap_w22", rf_wsel, 22);
        drv_md(0, 0, 0);
        tick();
        check("wrap_w23", rf_wsel, 23);
        check("wrap_d23", rf_wdat, 32'hA3);
        tick();
        check("wrap_idle", rf_wen, 0);

        // Same-register ALU write over a buffered result.
        drv_md(1, 5, 32'hAA);
        tick();
        drv_md(0, 0, 0);
        drv_alu(1, 5, 32'hBB);
        tick();
        check("stale_alu_wsel", rf_wsel, 5);
        check("stale_alu_wdat", rf_wdat, 32'hBB);
        drv_alu(0, 0, 0);
        tick();
        check("stale_wen", rf_wen, KILL ? 0 : 1);
        if (!KILL) check("stale_wdat", rf_wdat, 32'hAA);
        tick();
        check("stale_done_wen", rf_wen, 0);
        check("stale_done_pend", md_pending, 0);

        // Randomized traffic with occasional mid-operation resets.
        for (int n = 0; n < 4000; n++) begin
            RST = ($urandom_range(0, 249) == 0);
            if (!m_stall) begin
                drv_alu($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom);
            end
            drv_md($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
            tick();
        end
        RST = 1'b0;
        drv_alu(0, 0, 0);
        drv_md(0, 0, 0);
        for (int n = 0; n < 8; n++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
